// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator on the system clock with a pixel clock-enable.
// Counter state is decoded into sync, window and colour, then registered once per CE.
module vga_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC_W    = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC_W    = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int COLOR_W     = 4,
    parameter int CHECK_SHIFT = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PIX_CE,
    input  logic [1:0]         MODE,
    output logic               H_SYNC,
    output logic               V_SYNC,
    output logic               RGB_EN,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic [10:0]        X,
    output logic [10:0]        Y,
    output logic               FRAME_START
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
    localparam int GRAD_STEP = H_ACTIVE >> COLOR_W;
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

    logic [10:0]        h_cnt, v_cnt;
    logic [10:0]        grad_cnt, bar_cnt;
    logic [COLOR_W-1:0] grad_lvl;
    logic [2:0]         bar_idx;
    logic [1:0]         active_mode, mode_eff;
    logic               h_last, v_last, frame_first, active, hs_on, vs_on;
    logic [COLOR_W-1:0] r, g, b;

    assign h_last      = (h_cnt == 11'(H_TOTAL - 1));
    assign v_last      = (v_cnt == 11'(V_TOTAL - 1));
    assign frame_first = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    assign active      = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
    assign hs_on       = (h_cnt >= 11'(H_ACTIVE + H_FP)) && (h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC_W));
    assign vs_on       = (v_cnt >= 11'(V_ACTIVE + V_FP)) && (v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC_W));
    // Pixel (0,0) already uses the MODE being latched on this CE.
    assign mode_eff    = frame_first ? MODE : active_mode;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (PIX_CE) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            active_mode <= 2'd0;
        end else if (PIX_CE && frame_first) begin
            active_mode <= MODE;
        end
    end

    // Step counters track X/GRAD_STEP and X/BAR_W without dividers; cleared at line wrap.
    always_ff @(posedge CLK) begin
        if (RESET || (PIX_CE && h_last)) begin
            grad_cnt <= '0;
            grad_lvl <= '0;
            bar_cnt  <= '0;
            bar_idx  <= '0;
        end else if (PIX_CE) begin
            if (grad_cnt == 11'(GRAD_STEP - 1)) begin
                grad_cnt <= '0;
                if (grad_lvl != FULL) grad_lvl <= grad_lvl + 1'b1;
            end else begin
                grad_cnt <= grad_cnt + 11'd1;
            end
            if (bar_cnt == 11'(BAR_W - 1)) begin
                bar_cnt <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 11'd1;
            end
        end
    end

    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        if (active) begin
            case (mode_eff)
                2'd0: begin
                    // Bar order white,yellow,cyan,green,magenta,red,blue,black.
                    r = bar_idx[1] ? '0 : FULL;
                    g = bar_idx[2] ? '0 : FULL;
                    b = bar_idx[0] ? '0 : FULL;
                end
                2'd1: begin
                    if (h_cnt[CHECK_SHIFT] ^ v_cnt[CHECK_SHIFT]) begin
                        r = FULL;
                        g = FULL;
                        b = FULL;
                    end
                end
                2'd2: begin
                    r = grad_lvl;
                    g = grad_lvl;
                    b = grad_lvl;
                end
                default: begin
                    if (h_cnt == 11'd0 || h_cnt == 11'(H_ACTIVE - 1) ||
                        v_cnt == 11'd0 || v_cnt == 11'(V_ACTIVE - 1)) begin
                        r = FULL;
                        g = FULL;
                        b = FULL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            H_SYNC      <= ~SYNC_POL;
            V_SYNC      <= ~SYNC_POL;
            RGB_EN      <= 1'b0;
            RED         <= '0;
            GREEN       <= '0;
            BLUE        <= '0;
            X           <= '0;
            Y           <= '0;
            FRAME_START <= 1'b0;
        end else if (PIX_CE) begin
            H_SYNC      <= hs_on ? SYNC_POL : ~SYNC_POL;
            V_SYNC      <= vs_on ? SYNC_POL : ~SYNC_POL;
            RGB_EN      <= active;
            RED         <= r;
            GREEN       <= g;
            BLUE        <= b;
            X           <= h_cnt;
            Y           <= v_cnt;
            FRAME_START <= frame_first;
        end
    end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator. It is the successor to the fixed 640x480 colour-bar top level. It generates H/V sync and the active-video window from parameterised porch and sync widths, and drives multi-bit RGB with four run-time-selectable patterns. It runs on the system clock with a pixel clock-enable in place of a divided clock, and feeds the DAC/resistor-ladder pins directly.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)
COLOR_W, 4, bits per colour channel
CHECK_SHIFT, 5, checkerboard square size = 2^CHECK_SHIFT pixels

Ports:
CLK  in  1  system clock; the only clock
RESET  in  1  synchronous, active-high reset
PIX_CE  in  1  pixel enable; the generator advances only on CLK edges with PIX_CE=1
MODE  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 border
H_SYNC  out  1  horizontal sync at SYNC_POL when asserted
V_SYNC  out  1  vertical sync at SYNC_POL when asserted
RGB_EN  out  1  high while the current pixel is in the active region
RED  out  COLOR_W  red channel
GREEN  out  COLOR_W  green channel
BLUE  out  COLOR_W  blue channel
X  out  11  active pixel column; valid when RGB_EN=1
Y  out  11  active line; valid when RGB_EN=1
FRAME_START  out  1  one-CE pulse coincident with pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults are 800 and 525.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1 to 0.
  - Both counters change only when PIX_CE=1.
- Regions: active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - H sync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - V sync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes on the same CE as v_cnt, i.e. at h_cnt wrap.
- Pipeline:
  - All outputs are registered with a latency of one PIX_CE from the counter state.
  - Sync, RGB_EN, X/Y, colour and FRAME_START are always mutually aligned.
  - All outputs hold their value on cycles with PIX_CE=0.
- Blanking: RED/GREEN/BLUE are driven to 0 whenever RGB_EN=0. Outputs are never high-impedance.
- Mode latch:
  - MODE is sampled into an internal active-mode register only at h_cnt=0, v_cnt=0 with PIX_CE=1.
  - A mid-frame MODE change takes effect at the next frame.
- Patterns, with full = all ones and none = 0:
  - Mode 0, 8 vertical bars, each H_ACTIVE/8 wide. Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 1, checkerboard: white if X[CHECK_SHIFT]^Y[CHECK_SHIFT] is 1, else black.
  - Mode 2, horizontal grey ramp:
    - All channels equal level = X / (H_ACTIVE>>COLOR_W), saturated at 2^COLOR_W-1.
    - Implemented with a step counter reset at X=0; no divider.
  - Mode 3, border: white on X=0, X=H_ACTIVE-1, Y=0, Y=V_ACTIVE-1; black elsewhere.
- Reset (synchronous, overrides PIX_CE):
  - h_cnt=v_cnt=0 and active mode=0.
  - H_SYNC/V_SYNC deasserted (~SYNC_POL), RGB_EN=0, RGB=0, X=Y=0, FRAME_START=0.
  - Reset mid-frame truncates the frame. The first CE after release starts a fresh frame at (0,0) with FRAME_START.
- Widths: X and Y are zero-extended to 11 bits. Parameters satisfy H_TOTAL, V_TOTAL ≤ 2048 and H_ACTIVE divisible by 8 and by 2^COLOR_W.

Test Plan:
- Defaults, PIX_CE=1 constantly, MODE=0, release RESET:
  - FRAME_START recurs exactly every 420000 CEs.
  - H_SYNC is low for 96 CEs starting 656 CEs after each line's first pixel; line period is 800.
  - V_SYNC is low for 2 lines starting at line 490.
- Mode 0: pixel X=79 is white (F,F,F); X=80 is yellow (F,F,0); X=559 is blue (0,0,F); X=560..639 are black; X=640..799 have RGB=0 and RGB_EN=0.
- PIX_CE toggling 1/0, MODE=2: all outputs are stable on PIX_CE=0 cycles. Line period is 1600 CLKs; gray is 0 at X=0..39, 1 at X=40, 15 at X=639.
- MODE changed 0→1 at line 100: the current frame stays bars. The next frame shows checker: pixel (32,0) is white and (32,32) is black.
- RESET asserted at line 300, X=200 for 3 CLKs:
  - The next CLK after the first reset edge shows H_SYNC=V_SYNC=1, RGB_EN=0, RGB=0.
  - After release, the first CE yields FRAME_START=1, X=Y=0.
- SYNC_POL=1, COLOR_W=2, MODE=3: sync pulses are high-active. Border pixels are 3,3,3; (1,1) is 0,0,0; the full frame period is unchanged.
